mips_cpu_mem_arbiter: RTL and testbench

- Shares one single-port, Avalon-style memory bus between the CPU instruction-fetch port and the CPU data port.
- Sits between the CPU core and the unified memory.
- Serialises requests, holds them across `mem_waitrequest` stalls, and returns read data with one-cycle completion pulses.
- Lets the core run against a single memory instead of split instruction/data arrays.

---
 rtl/mips_cpu_mem_arbiter_if.sv | 55 +++++
 rtl/mips_cpu_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_mem_arbiter_if.sv
// rtl/mips_cpu_mem_arbiter_if.sv - instruction/data/memory bus bundle around the arbiter
//
// Groups the three buses the arbiter joins:
//   instr_*  : fetch port (read-only, held until instr_valid)
//   data_*   : load/store port (held until data_done)
//   mem_*    : single-port Avalon-style memory bus
//   busy     : arbiter is in a non-idle state
// modport slave  : the arbiter (serves the CPU ports, drives the memory bus)
// modport master : the environment (CPU core requesters plus memory)
interface mips_cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              instr_read;
    logic [ADDR_W-1:0] instr_address;
    logic [31:0]       instr_readdata;
    logic              instr_valid;

    logic              data_read;
    logic              data_write;
    logic [ADDR_W-1:0] data_address;
    logic [31:0]       data_writedata;
    logic [3:0]        data_byteenable;
    logic [31:0]       data_readdata;
    logic              data_done;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [3:0]        mem_byteenable;
    logic              mem_waitrequest;
    logic [31:0]       mem_readdata;

    logic              busy;

    modport slave (
        input  instr_read, instr_address,
        output instr_readdata, instr_valid,
        input  data_read, data_write, data_address, data_writedata, data_byteenable,
        output data_readdata, data_done,
        output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        input  mem_waitrequest, mem_readdata,
        output busy
    );

    modport master (
        output instr_read, instr_address,
        input  instr_readdata, instr_valid,
        output data_read, data_write, data_address, data_writedata, data_byteenable,
        input  data_readdata, data_done,
        input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        output mem_waitrequest, mem_readdata,
        input  busy
    );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// rtl/mips_cpu_mem_arbiter.sv - shares one memory bus between CPU fetch and data ports
//
// Serialises fetch and load/store requests onto one Avalon-style bus, holds the
// access across mem_waitrequest, and returns read data with a one-cycle
// instr_valid / data_done pulse. Collisions are resolved round-robin, starting
// with the data port when DATA_FIRST is 1. All outputs are registered.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   bus        : instr_*, data_*, mem_* and busy (see mips_cpu_mem_arbiter_if)
//   perf_*     : grant and wait-cycle counters, present only when
//                MIPS_MEM_ARB_PERF_EN is defined
module mips_cpu_mem_arbiter #(
    parameter int DATA_FIRST = 1,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_cpu_mem_arbiter_if.slave   bus
`ifdef MIPS_MEM_ARB_PERF_EN
    ,
    output logic [31:0]             perf_instr_grants,
    output logic [31:0]             perf_data_grants,
    output logic [31:0]             perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_DATA} state_t;

    state_t            state, state_n;
    logic              ptr, ptr_n;          // 1: data port wins the next collision
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              rd_q, rd_n, wr_q, wr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [3:0]        be_q, be_n;
    logic [31:0]       irdata_q, irdata_n, drdata_q, drdata_n;
    logic              ivalid_q, ivalid_n, ddone_q, ddone_n;
    logic              instr_elig, data_elig, grant_instr, grant_data;

    always_comb begin
        // A port whose completion pulse is high is still holding the request it
        // just had served, so it must not be granted again this cycle.
        instr_elig  = bus.instr_read & ~ivalid_q;
        data_elig   = (bus.data_read | bus.data_write) & ~ddone_q;
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        state_n     = state;
        ptr_n       = ptr;
        addr_n      = addr_q;
        rd_n        = rd_q;
        wr_n        = wr_q;
        wdata_n     = wdata_q;
        be_n        = be_q;
        irdata_n    = irdata_q;
        drdata_n    = drdata_q;
        ivalid_n    = 1'b0;
        ddone_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (instr_elig && data_elig) begin
                    grant_data  = ptr;
                    grant_instr = ~ptr;
                    ptr_n       = ~ptr;
                end else begin
                    grant_instr = instr_elig;
                    grant_data  = data_elig;
                end
                if (grant_instr) begin
                    state_n = ST_INSTR;
                    addr_n  = bus.instr_address;
                    be_n    = 4'hF;
                    rd_n    = 1'b1;
                    wr_n    = 1'b0;
                end else if (grant_data) begin
                    state_n = ST_DATA;
                    addr_n  = bus.data_address;
                    be_n    = bus.data_byteenable;
                    wdata_n = bus.data_writedata;
                    // A write wins if the core raises both strobes.
                    wr_n    = bus.data_write;
                    rd_n    = ~bus.data_write;
                end
            end
            ST_INSTR: begin
                if (!bus.mem_waitrequest) begin
                    irdata_n = bus.mem_readdata;
                    ivalid_n = 1'b1;
                    rd_n     = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!bus.mem_waitrequest) begin
                    if (rd_q) begin
                        drdata_n = bus.mem_readdata;
                    end
                    ddone_n = 1'b1;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= (DATA_FIRST != 0);
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            ivalid_q <= 1'b0;
            ddone_q  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            addr_q   <= addr_n;
            rd_q     <= rd_n;
            wr_q     <= wr_n;
            wdata_q  <= wdata_n;
            be_q     <= be_n;
            irdata_q <= irdata_n;
            drdata_q <= drdata_n;
            ivalid_q <= ivalid_n;
            ddone_q  <= ddone_n;
        end
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_read       = rd_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_writedata  = wdata_q;
    assign bus.mem_byteenable = be_q;
    assign bus.instr_readdata = irdata_q;
    assign bus.instr_valid    = ivalid_q;
    assign bus.data_readdata  = drdata_q;
    assign bus.data_done      = ddone_q;
    assign bus.busy           = (state != ST_IDLE);

`ifdef MIPS_MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_instr_grants <= '0;
            perf_data_grants  <= '0;
            perf_wait_cycles  <= '0;
        end else begin
            if (grant_instr) begin
                perf_instr_grants <= perf_instr_grants + 32'd1;
            end
            if (grant_data) begin
                perf_data_grants <= perf_data_grants + 32'd1;
            end
            if (state != ST_IDLE && bus.mem_waitrequest) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb/tb_mips_cpu_mem_arbiter.sv - scoreboard bench for mips_cpu_mem_arbiter
module tb_mips_cpu_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_cpu_mem_arbiter_if #(.ADDR_W(32)) bus();

`ifdef MIPS_MEM_ARB_PERF_EN
    logic [31:0] perf_instr_grants, perf_data_grants, perf_wait_cycles;
`endif

    mips_cpu_mem_arbiter #(.DATA_FIRST(1), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MIPS_MEM_ARB_PERF_EN
        ,
        .perf_instr_grants (perf_instr_grants),
        .perf_data_grants  (perf_data_grants),
        .perf_wait_cycles  (perf_wait_cycles)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } grant_t;

    typedef struct packed {
        logic        rd;
        logic [31:0] rdata;
    } ddone_t;

    grant_t      exp_grant[$];
    logic [31:0] exp_irdata[$];
    ddone_t      exp_ddone[$];

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2402_0005;
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model: stalls accesses to wait_addr for wait_cfg cycles.
    int          wait_cfg  = 0;
    logic [31:0] wait_addr = 32'h0;
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) begin
                if (bus.mem_address == wait_addr && wait_cnt < wait_cfg) begin
                    bus.mem_waitrequest = 1'b1;
                    bus.mem_readdata    = 32'hBAD0_BAD0;
                    wait_cnt++;
                end else begin
                    bus.mem_waitrequest = 1'b0;
                    bus.mem_readdata    = rd_fn(bus.mem_address);
                end
            end else begin
                wait_cnt            = 0;
                bus.mem_waitrequest = 1'b0;
                bus.mem_readdata    = 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor: grants and completions are popped from the scoreboard queues.
    int          cyc = 0;
    logic        prev_strobe = 1'b0, prev_iv = 1'b0, prev_dd = 1'b0;
    logic [31:0] held_addr = 32'h0;
    int          strobe_len = 0, last_strobe_len = 0;
    int          iv_cyc = 0, dd_cyc = 0, iv_count = 0, dd_count = 0;
    grant_t      mon_g;
    ddone_t      mon_d;
    logic        strobe;

    always @(negedge clk) begin
        cyc++;
        strobe = bus.mem_read | bus.mem_write;
        if (reset) begin
            prev_strobe = 1'b0;
            prev_iv     = 1'b0;
            prev_dd     = 1'b0;
            strobe_len  = 0;
        end else begin
            if (strobe && !prev_strobe) begin
                check("grant_expected", exp_grant.size() != 0, 1);
                if (exp_grant.size() != 0) begin
                    mon_g = exp_grant.pop_front();
                    check("grant_addr", bus.mem_address, mon_g.addr);
                    check("grant_rw", {bus.mem_write, bus.mem_read}, mon_g.wr ? 2'b10 : 2'b01);
                    check("grant_be", bus.mem_byteenable, mon_g.be);
                    if (mon_g.wr) check("grant_wdata", bus.mem_writedata, mon_g.wdata);
                end
                held_addr  = bus.mem_address;
                strobe_len = 1;
            end else if (strobe) begin
                check("hold_addr", bus.mem_address, held_addr);
                strobe_len++;
            end else if (prev_strobe) begin
                last_strobe_len = strobe_len;
            end
            if (bus.instr_valid) begin
                iv_count++;
                iv_cyc = cyc;
                check("instr_valid_pulse", prev_iv, 0);
                check("instr_done_expected", exp_irdata.size() != 0, 1);
                if (exp_irdata.size() != 0) check("instr_readdata", bus.instr_readdata, exp_irdata.pop_front());
            end
            if (bus.data_done) begin
                dd_count++;
                dd_cyc = cyc;
                check("data_done_pulse", prev_dd, 0);
                check("data_done_expected", exp_ddone.size() != 0, 1);
                if (exp_ddone.size() != 0) begin
                    mon_d = exp_ddone.pop_front();
                    if (mon_d.rd) check("data_readdata", bus.data_readdata, mon_d.rdata);
                end
            end
            prev_strobe = strobe;
            prev_iv     = bus.instr_valid;
            prev_dd     = bus.data_done;
        end
    end

    task automatic instr_req(input logic [31:0] a);
        int t;
        exp_irdata.push_back(rd_fn(a));
        bus.instr_address = a;
        bus.instr_read    = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.instr_valid && t < 300);
        check("instr_timeout", bus.instr_valid, 1);
        bus.instr_read = 1'b0;
    endtask

    task automatic data_req(input logic [31:0] a, input logic wr, input logic also_read,
                            input logic [3:0] be, input logic [31:0] wd);
        int t;
        exp_ddone.push_back('{rd: ~wr, rdata: (wr ? 32'h0 : rd_fn(a))});
        bus.data_address    = a;
        bus.data_write      = wr;
        bus.data_read       = ~wr | also_read;
        bus.data_byteenable = be;
        bus.data_writedata  = wd;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.data_done && t < 300);
        check("data_timeout", bus.data_done, 1);
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, dd_before;
        reset = 1'b1;
        bus.instr_read = 1'b0; bus.instr_address = '0;
        bus.data_read = 1'b0; bus.data_write = 1'b0; bus.data_address = '0;
        bus.data_writedata = '0; bus.data_byteenable = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_data_done", bus.data_done, 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_mem_be", bus.mem_byteenable, 0);
        check("rst_instr_rdata", bus.instr_readdata, 0);
        check("rst_data_rdata", bus.data_readdata, 0);
        reset = 1'b0;

        // Single fetch with minimum latency
        exp_grant.push_back('{addr: 32'hBFC0_0000, wr: 1'b0, be: 4'hF, wdata: 32'h0});
        exp_irdata.push_back(32'h2402_0005);
        @(negedge clk);
        bus.instr_address = 32'hBFC0_0000;
        bus.instr_read    = 1'b1;
        @(posedge clk); #1;
        check("fetch_mem_read", bus.mem_read, 1);
        check("fetch_mem_addr", bus.mem_address, 32'hBFC0_0000);
        check("fetch_mem_be", bus.mem_byteenable, 4'hF);
        check("fetch_busy", bus.busy, 1);
        check("fetch_valid_early", bus.instr_valid, 0);
        @(posedge clk); #1;
        check("fetch_valid", bus.instr_valid, 1);
        check("fetch_rdata", bus.instr_readdata, 32'h2402_0005);
        check("fetch_strobe_off", bus.mem_read, 0);
        bus.instr_read = 1'b0;
        @(posedge clk); #1;
        check("fetch_valid_one_cycle", bus.instr_valid, 0);
        check("fetch_rdata_hold", bus.instr_readdata, 32'h2402_0005);

        // Collision after reset: data first, write wins over read
        @(negedge clk);
        exp_grant.push_back('{addr: 32'h1004, wr: 1'b1, be: 4'hF, wdata: 32'hDEAD_BEEF});
        exp_grant.push_back('{addr: 32'h2400, wr: 1'b0, be: 4'hF, wdata: 32'h0});
        fork
            data_req(32'h1004, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF);
            instr_req(32'h2400);
        join
        @(negedge clk);
        check("collision_spacing", iv_cyc - dd_cyc, 2);

        // Wait states on a load
        wait_addr = 32'h1000;
        wait_cfg  = 3;
        exp_grant.push_back('{addr: 32'h1000, wr: 1'b0, be: 4'hF, wdata: 32'h0});
        data_req(32'h1000, 1'b0, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        check("wait_strobe_len", last_strobe_len, 4);
        wait_cfg = 0;

        // Round-robin with both ports held continuously
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_grant.push_back('{addr: 32'h1100 + 32'(4 * k), wr: 1'b0, be: 4'h3, wdata: 32'h0});
            exp_grant.push_back('{addr: 32'h0400 + 32'(4 * k), wr: 1'b0, be: 4'hF, wdata: 32'h0});
        end
        fork
            begin
                for (int k = 0; k < 3; k++) data_req(32'h1100 + 32'(4 * k), 1'b0, 1'b0, 4'h3, 32'h0);
            end
            begin
                for (int k = 0; k < 3; k++) instr_req(32'h0400 + 32'(4 * k));
            end
        join
        @(negedge clk);

        // Reset in the middle of a stalled store
        wait_addr = 32'h3000;
        wait_cfg  = 1000;
        dd_before = dd_count;
        exp_grant.push_back('{addr: 32'h3000, wr: 1'b1, be: 4'hC, wdata: 32'h1122_3344});
        bus.data_address    = 32'h3000;
        bus.data_write      = 1'b1;
        bus.data_byteenable = 4'hC;
        bus.data_writedata  = 32'h1122_3344;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.mem_write && t < 50);
        check("abort_granted", bus.mem_write, 1);
        repeat (3) @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_mem_write", bus.mem_write, 0);
        check("abort_mem_read", bus.mem_read, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_mem_addr", bus.mem_address, 0);
        wait_cfg = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("abort_no_done", dd_count - dd_before, 0);
        exp_grant.push_back('{addr: 32'h3000, wr: 1'b1, be: 4'hC, wdata: 32'h1122_3344});
        exp_ddone.push_back('{rd: 1'b0, rdata: 32'h0});
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.data_done && t < 50);
        check("reissue_done", bus.data_done, 1);
        bus.data_write = 1'b0;
        @(negedge clk);
        check("reissue_done_count", dd_count - dd_before, 1);

`ifdef MIPS_MEM_ARB_PERF_EN
        // Counters over a collision with two stall cycles on the fetch
        do_reset();
        check("perf_rst_wait", perf_wait_cycles, 0);
        wait_addr = 32'h2400;
        wait_cfg  = 2;
        exp_grant.push_back('{addr: 32'h1004, wr: 1'b1, be: 4'hF, wdata: 32'hDEAD_BEEF});
        exp_grant.push_back('{addr: 32'h2400, wr: 1'b0, be: 4'hF, wdata: 32'h0});
        fork
            data_req(32'h1004, 1'b1, 1'b0, 4'hF, 32'hDEAD_BEEF);
            instr_req(32'h2400);
        join
        @(negedge clk);
        check("perf_instr_grants", perf_instr_grants, 1);
        check("perf_data_grants", perf_data_grants, 1);
        check("perf_wait_cycles", perf_wait_cycles, 2);
        wait_cfg = 0;
`endif

        repeat (2) @(negedge clk);
        check("grant_queue_drained", exp_grant.size(), 0);
        check("instr_queue_drained", exp_irdata.size(), 0);
        check("data_queue_drained", exp_ddone.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
